// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch: PC, one-at-a-time imem read, held instruction register.
// Optional watchdog on the memory response is built only when FETCH_TIMEOUT_EN is defined.
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic        InstrAck,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        Fault
);

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {StFetch, StWait, StValid, StHalt} state_e;

    state_e      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        fault_q;
    logic [31:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_q;
`endif

    assign next_pc = PCSrc ? PCTarget : PCPlus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StFetch;
            pc_q    <= RESET_PC;
            instr_q <= NopInstr;
            fault_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= 16'd0;
`endif
        end else begin
            unique case (state)
                StFetch: begin
                    state <= StWait;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt_q <= 16'd0;
`endif
                end
                StWait: begin
                    // A response in the final allowed cycle still wins over the timeout.
                    if (ImemRvalid) begin
                        instr_q <= ImemRdata;
                        state   <= StValid;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wait_cnt_q == TimeoutLast) begin
                        fault_q <= 1'b1;
                        state   <= StHalt;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
`endif
                end
                StValid: begin
                    if (InstrAck) begin
                        if (next_pc[1:0] != 2'b00) begin
                            fault_q <= 1'b1;
                            state   <= StHalt;
                        end else begin
                            pc_q  <= next_pc;
                            state <= StFetch;
                        end
                    end
                end
                StHalt: begin
                    state <= StHalt;
                end
            endcase
        end
    end

    // Gated by reset so the strobe stays low while reset is held.
    assign ImemReq    = (state == StFetch) && !reset;
    assign ImemAddr   = pc_q;
    assign PC         = pc_q;
    assign PCPlus4    = pc_q + 32'd4;
    assign Instr      = instr_q;
    assign InstrValid = (state == StValid);
    assign Fault      = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch against a transaction-level PC/fault model.
module tb_instr_fetch;

    localparam logic [31:0] ResetPc = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        InstrAck;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        Fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_pc;
    logic        model_fault;
    logic [31:0] last_word;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC      (ResetPc),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemRvalid(ImemRvalid),
        .ImemRdata (ImemRdata),
        .Instr     (Instr),
        .InstrValid(InstrValid),
        .PC        (PC),
        .PCPlus4   (PCPlus4),
        .InstrAck  (InstrAck),
        .PCSrc     (PCSrc),
        .PCTarget  (PCTarget),
        .Fault     (Fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_idle();
        ImemRvalid = 1'b0;
        ImemRdata  = $urandom;
        InstrAck   = 1'($urandom);
        PCSrc      = 1'($urandom);
        PCTarget   = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_idle();
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            sample();
            chk1("rst_req", ImemReq, 1'b0);
            chk1("rst_ivalid", InstrValid, 1'b0);
            chk1("rst_fault", Fault, 1'b0);
            chk("rst_pc", PC, ResetPc);
            chk("rst_instr", Instr, 32'h0000_0013);
        end
        next_cycle();
        reset       = 1'b0;
        model_pc    = ResetPc;
        model_fault = 1'b0;
    endtask

    // One full instruction: request, lat empty WAIT cycles, response, ackdly held VALID cycles, ack.
    task automatic do_instr(input int lat, input int ackdly, input logic src,
                            input logic [31:0] tgt, input logic [31:0] word);
        logic [31:0] exp_next;
        sample();
        chk1("fetch_req", ImemReq, 1'b1);
        chk("fetch_addr", ImemAddr, model_pc);
        chk1("fetch_ivalid", InstrValid, 1'b0);
        chk1("fetch_fault", Fault, 1'b0);
        next_cycle();
        for (int i = 0; i < lat; i++) begin
            sample();
            chk1("wait_req", ImemReq, 1'b0);
            chk1("wait_ivalid", InstrValid, 1'b0);
            next_cycle();
            set_idle();
        end
        ImemRvalid = 1'b1;
        ImemRdata  = word;
        sample();
        chk1("resp_req", ImemReq, 1'b0);
        chk1("resp_ivalid", InstrValid, 1'b0);
        next_cycle();
        for (int i = 0; i <= ackdly; i++) begin
            ImemRvalid = 1'b1 & 1'($urandom);
            ImemRdata  = $urandom;
            if (i < ackdly) begin
                InstrAck = 1'b0;
                PCSrc    = 1'($urandom);
                PCTarget = $urandom;
            end else begin
                InstrAck = 1'b1;
                PCSrc    = src;
                PCTarget = tgt;
            end
            sample();
            chk1("valid_ivalid", InstrValid, 1'b1);
            chk("valid_instr", Instr, word);
            chk("valid_pc", PC, model_pc);
            chk("valid_pcplus4", PCPlus4, model_pc + 32'd4);
            chk1("valid_req", ImemReq, 1'b0);
            next_cycle();
        end
        set_idle();
        last_word = word;
        exp_next  = src ? tgt : model_pc + 32'd4;
        if (exp_next[1:0] != 2'b00) model_fault = 1'b1;
        else model_pc = exp_next;
    endtask

    task automatic check_halt(input int n);
        for (int i = 0; i < n; i++) begin
            InstrAck   = 1'b1;
            ImemRvalid = 1'($urandom);
            ImemRdata  = $urandom;
            PCSrc      = 1'b0;
            sample();
            chk1("halt_fault", Fault, model_fault);
            chk1("halt_req", ImemReq, 1'b0);
            chk1("halt_ivalid", InstrValid, 1'b0);
            chk("halt_pc", PC, model_pc);
            chk("halt_instr", Instr, last_word);
            next_cycle();
        end
        set_idle();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        do_reset();

        // Minimum latency from reset, then slow memory with held-off ack.
        do_instr(0, 0, 1'b0, 32'h0, 32'h00a0_0093);
        do_instr(5, 3, 1'b0, 32'h0, 32'h0011_8193);
        // Taken branch to 0x40, then wrap-around from the top of memory.
        do_instr(0, 0, 1'b1, 32'h0000_0040, 32'h0000_006f);
        do_instr(1, 1, 1'b1, 32'hFFFF_FFFC, 32'hfe00_0ee3);
        do_instr(0, 0, 1'b0, 32'h0000_0001, 32'h0000_0013);
        do_instr(2, 0, 1'b0, 32'h0, 32'h0040_0113);

        for (int k = 0; k < 16; k++) begin
            do_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'($urandom),
                     $urandom & 32'hFFFF_FFFC, $urandom);
        end

        // Reset while waiting on memory restarts cleanly.
        sample();
        chk1("midwait_req", ImemReq, 1'b1);
        next_cycle();
        sample();
        chk1("midwait_req2", ImemReq, 1'b0);
        do_reset();
        do_instr(1, 0, 1'b0, 32'h0, 32'h1234_5013);

        // Misaligned target: halt with old PC and ignore further traffic until reset.
        do_instr(0, 1, 1'b1, 32'h0000_0042, 32'h0420_006f);
        check_halt(4);
        do_reset();
        do_instr(0, 0, 1'b0, 32'h0, 32'h0000_0093);

`ifdef FETCH_TIMEOUT_EN
        do_reset();
        sample();
        chk1("to_req", ImemReq, 1'b1);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            ImemRvalid = 1'b0;
            sample();
            chk1("to_wait_fault", Fault, 1'b0);
            next_cycle();
        end
        model_fault = 1'b1;
        last_word   = 32'h0000_0013;
        check_halt(2);

        do_reset();
        sample();
        chk1("to2_req", ImemReq, 1'b1);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            ImemRvalid = 1'b0;
            sample();
            chk1("to2_wait_fault", Fault, 1'b0);
            next_cycle();
        end
        ImemRvalid = 1'b1;
        ImemRdata  = 32'hcafe_0013;
        sample();
        next_cycle();
        set_idle();
        InstrAck = 1'b0;
        sample();
        chk1("to2_ivalid", InstrValid, 1'b1);
        chk("to2_instr", Instr, 32'hcafe_0013);
        chk1("to2_fault", Fault, 1'b0);
        next_cycle();
        do_reset();
`else
        // Without the watchdog a very slow memory never faults.
        do_instr(20, 0, 1'b0, 32'h0, 32'h0bad_0013);
`endif
        do_instr(0, 0, 1'b0, 32'h0, 32'h0000_0113);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Multi-cycle instruction fetch unit for the RISC-V core. Holds the program counter, issues one read per instruction to a variable-latency instruction memory, and captures the returned word into a stable instruction register. Instr[31:7] feeds the immediate extender, and the full word feeds the decoder. The execute side returns the next-PC choice (PCSrc and PCTarget, computed from the extended immediate) when it retires the held instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 255, WAIT cycles without response before fault (1..65535); used only with FETCH_TIMEOUT_EN.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ImemReq  out  1  one-cycle read request strobe
- ImemAddr  out  32  read address; equals PC
- ImemRvalid  in  1  read data valid
- ImemRdata  in  32  read data
- Instr  out  32  held instruction word; Instr[31:7] goes to the immediate extender
- InstrValid  out  1  Instr/PC are valid for execution
- PC  out  32  address of held instruction
- PCPlus4  out  32  PC + 4, modulo 2^32
- InstrAck  in  1  execute side retires the held instruction this cycle
- PCSrc  in  1  1: next PC = PCTarget; 0: next PC = PCPlus4
- PCTarget  in  32  branch/jump target
- Fault  out  1  sticky fault flag (misaligned target, or timeout)

## Operation
- States: FETCH, WAIT, VALID, HALT. Reset state is FETCH.
- FETCH:
  - ImemReq=1 and ImemAddr=PC for exactly one cycle.
  - Next state is WAIT.
- WAIT:
  - ImemReq=0.
  - On ImemRvalid=1: Instr<=ImemRdata and go to VALID.
  - Otherwise stay in WAIT.
- VALID:
  - InstrValid=1. Instr and PC are held stable until InstrAck.
  - On InstrAck=1, compute next = PCSrc ? PCTarget : PCPlus4.
    - If next[1:0]!=0: PC is not updated, Fault<=1, go to HALT.
    - Otherwise: PC<=next and go to FETCH.
- HALT:
  - ImemReq=0, InstrValid=0, Fault=1, and all registers are frozen.
  - Only reset exits HALT.
- Input qualification:
  - ImemRvalid outside WAIT is ignored.
  - InstrAck outside VALID is ignored.
  - PCSrc and PCTarget are sampled only in the cycle of a qualified InstrAck.
- Only one memory request is outstanding at a time. The instruction memory must share the same reset, so no stale response survives a reset.
- PCPlus4 is combinational from the PC register. PC 32'hFFFF_FFFC gives PCPlus4 = 32'h0000_0000 (wrap-around, not a fault).

## Timing
- Reset values: PC=RESET_PC, Instr=32'h0000_0013 (NOP), InstrValid=0, ImemReq=0, Fault=0, state FETCH. If enabled, the timeout counter is also 0.
- Reset asserted in any state, including mid-WAIT or in HALT, returns to these values on the next edge.
- The first ImemReq appears in the first cycle after reset deasserts.
- Minimum fetch latency:
  - ImemReq in cycle N.
  - ImemRvalid in cycle N+1.
  - InstrValid=1 in cycle N+2.
- An InstrAck in cycle N+2 gives the next ImemReq in N+3. Peak throughput is one instruction per 3 cycles.
- Each extra memory wait cycle adds one cycle of latency.
- InstrValid deasserts in the cycle after the acknowledging edge.
- Fault rises on the clock edge that detects the fault and stays high until reset.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle without ImemRvalid.
  - When it reaches TIMEOUT_CYCLES, Fault<=1 and the state goes to HALT.
  - ImemRvalid in that same cycle wins: the data is captured and there is no fault.
- FETCH_TIMEOUT_EN undefined:
  - No counter is built and WAIT waits indefinitely.
  - Fault is caused only by a misaligned target.

## Test plan
- Reset with RESET_PC=32'h0000_0100, memory responding after 1 cycle:
  - ImemReq/ImemAddr=0x100 in the first cycle after reset.
  - InstrValid in the third cycle with Instr = memory word.
  - PCPlus4=0x104.
- Memory delays ImemRvalid by 5 cycles and InstrAck is held off 3 cycles:
  - Instr and PC stay stable throughout.
  - Exactly one ImemReq per instruction.
  - Spurious ImemRvalid pulses while in VALID are ignored.
- Taken branch: InstrAck with PCSrc=1 and PCTarget=0x0000_0040 → next ImemAddr=0x40.
- Misaligned target: PCTarget=0x0000_0042 → Fault=1 and HALT. PC stays at the old value, no further ImemReq, and later InstrAck is ignored. Reset then clears Fault.
- Wrap-around: PC=0xFFFF_FFFC with PCSrc=0 → next ImemAddr=0x0000_0000 and no fault.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, memory never responds → Fault rises 4 cycles after entering WAIT. Repeat with ImemRvalid in exactly that cycle → data captured, Fault=0.
